// File: rtl/turbosound_multi_if.sv
// PSG bus bundle between the Z80 port decode and the TurboSound bank.
// Signals:
//   bdir, bc1 : PSG bus control strobes (CPU -> bank)
//   din       : PSG bus write data (CPU -> bank)
//   dout      : readback data from the selected chip (bank -> CPU)
//   oe_n      : readback output enable, active-low (bank -> CPU)
// Modports: master is the CPU/decoder side, slave is the bank controller.
interface turbosound_multi_if;
  logic       bdir;
  logic       bc1;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe_n;

  modport master (output bdir, output bc1, output din, input dout, input oe_n);
  modport slave  (input bdir, input bc1, input din, output dout, output oe_n);
endinterface

// File: rtl/turbosound_multi.sv
// N-chip PSG bank controller (generalised TurboSound selector).
// Decodes chip-select commands from the PSG bus, gates per-chip ENA,
// routes readback from the selected chip and runs a sequential stereo
// mixer over all 3*NUM_CHIPS channels with saturating outputs.
//
// Ports:
//   clk, reset          : system clock, asynchronous active-high reset
//   clk35en             : PSG clock enable, forwarded to enabled chips
//   clk175en            : mixer sample tick
//   disable_ay          : disables the whole bank
//   disable_turboay     : disables chips 1..NUM_CHIPS-1
//   pan_mode            : 0=ABC, 1=ACB, 2=mono, 3=ABC
//   psg                 : PSG bus (bdir, bc1, din, dout, oe_n), slave modport
//   chip_ena, chip_a8   : per-chip ENA and one-hot select
//   chip_dout/chip_oe_n : per-chip readback data / enable
//   chip_porta(_oe_n)   : per-chip port A data / output enable
//   chip_audio          : chip i: A [24i+23:24i+16], B [24i+15:24i+8], C [24i+7:24i]
//   audio_left/right    : saturated mixed samples
//   sample_valid        : one-clk pulse when a sample is published
//   overrun             : sticky, a sample tick arrived while busy
//   midi_out            : MIDI TX bit from selected chip's port A bit 2
//
// Optional feature macro: MIDI_OUT_EN (adds midi_out port and logic).
module turbosound_multi #(
  parameter int NUM_CHIPS = 2,
  parameter int CH_W      = 8,
  parameter int OUT_W     = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk35en,
  input  logic                          clk175en,
  input  logic                          disable_ay,
  input  logic                          disable_turboay,
  input  logic [1:0]                    pan_mode,
  turbosound_multi_if.slave             psg,
  output logic [NUM_CHIPS-1:0]          chip_ena,
  output logic [NUM_CHIPS-1:0]          chip_a8,
  input  logic [8*NUM_CHIPS-1:0]        chip_dout,
  input  logic [NUM_CHIPS-1:0]          chip_oe_n,
  input  logic [8*NUM_CHIPS-1:0]        chip_porta,
  input  logic [NUM_CHIPS-1:0]          chip_porta_oe_n,
  input  logic [3*CH_W*NUM_CHIPS-1:0]   chip_audio,
  output logic [OUT_W-1:0]              audio_left,
  output logic [OUT_W-1:0]              audio_right,
  output logic                          sample_valid,
  output logic                          overrun
`ifdef MIDI_OUT_EN
  ,
  output logic                          midi_out
`endif
);

  localparam int ACC_W = CH_W + $clog2(3 * NUM_CHIPS) + 1;
  localparam int SAT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [SAT_W-1:0] SAT_MAX = SAT_W'({OUT_W{1'b1}});

  typedef enum logic [1:0] {IDLE, SNAP, ACC, PUB} mix_state_t;

  logic [NUM_CHIPS-1:0]        chip_en;
  logic [2:0]                  sel;
  logic [2:0]                  sel_next;
  logic [2:0]                  cmd_idx;
  logic                        cmd_hit;
  logic                        sel_en;
  logic [7:0]                  rd_data;
  logic                        rd_oe_n;

  mix_state_t                  state;
  mix_state_t                  state_next;
  logic                        snap_load;
  logic                        acc_step;
  logic                        publish;
  logic                        drop;
  logic                        last_ch;
  logic [3*CH_W*NUM_CHIPS-1:0] snap;
  logic [ACC_W-1:0]            acc_l;
  logic [ACC_W-1:0]            acc_r;
  logic [2:0]                  chip_idx;
  logic [1:0]                  ch_idx;
  logic [CH_W-1:0]             chan_val;
  logic                        to_l;
  logic                        to_r;
  logic [SAT_W-1:0]            ext_l;
  logic [SAT_W-1:0]            ext_r;
  logic [OUT_W-1:0]            sat_l;
  logic [OUT_W-1:0]            sat_r;

  // Chip 0 is only gated by the bank-wide disable; the turbo chips also
  // honour disable_turboay.
  always_comb begin
    chip_en    = {NUM_CHIPS{~disable_ay & ~disable_turboay}};
    chip_en[0] = ~disable_ay;
  end

  assign chip_ena = chip_en & {NUM_CHIPS{clk35en}};

  // Select commands count down from 0xFF so that 0xFF/0xFE keep their
  // two-chip TurboSound meaning. A command wins over the forced fall-back
  // to chip 0 because it can only target an enabled chip.
  assign cmd_idx = ~psg.din[2:0];

  always_comb begin
    cmd_hit = 1'b0;
    sel_en  = 1'b0;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      if (cmd_idx == 3'(i) && chip_en[i]) cmd_hit = 1'b1;
      if (sel == 3'(i) && chip_en[i])     sel_en  = 1'b1;
    end
    if (!(psg.bdir && psg.bc1 && psg.din[7:3] == 5'b11111)) cmd_hit = 1'b0;
    sel_next = sel;
    if (cmd_hit)      sel_next = cmd_idx;
    else if (!sel_en) sel_next = 3'd0;
  end

  // Selection register; chip_a8 is registered from the same next value so
  // it always matches sel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel     <= 3'd0;
      chip_a8 <= NUM_CHIPS'(1);
    end else begin
      sel     <= sel_next;
      chip_a8 <= NUM_CHIPS'(1) << sel_next;
    end
  end

  // Readback mux; a disabled selected chip never drives the bus.
  always_comb begin
    rd_data = 8'h00;
    rd_oe_n = 1'b1;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      if (sel == 3'(i)) begin
        rd_data = chip_dout[8*i +: 8];
        rd_oe_n = chip_en[i] ? chip_oe_n[i] : 1'b1;
      end
    end
  end

  assign psg.dout = rd_data;
  assign psg.oe_n = rd_oe_n;

`ifdef MIDI_OUT_EN
  // MIDI TX is bit 2 of the selected chip's port A, only while that port
  // is actually driven as an output.
  always_comb begin
    midi_out = 1'b0;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      if (sel == 3'(i)) midi_out = ~chip_porta_oe_n[i] & chip_porta[8*i+2];
    end
  end
`else
  logic unused_porta;
  assign unused_porta = ^{chip_porta, chip_porta_oe_n};
`endif

  // Mixer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign last_ch = (chip_idx == 3'(NUM_CHIPS - 1)) && (ch_idx == 2'd2);

  // Mixer sequencing: snapshot, one channel per clock, then publish.
  // A tick that arrives while busy is dropped and flagged.
  always_comb begin
    state_next = state;
    snap_load  = 1'b0;
    acc_step   = 1'b0;
    publish    = 1'b0;
    drop       = clk175en && (state != IDLE);
    case (state)
      IDLE: if (clk175en) state_next = SNAP;
      SNAP: begin
        snap_load  = 1'b1;
        state_next = ACC;
      end
      ACC: begin
        acc_step = 1'b1;
        if (last_ch) state_next = PUB;
      end
      PUB: begin
        publish    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Current channel value from the snapshot (A sits in the top byte of
  // each chip's slice); disabled chips contribute silence.
  always_comb begin
    chan_val = '0;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (chip_idx == 3'(i) && ch_idx == 2'(j) && chip_en[i])
          chan_val = snap[(3*i + 2 - j)*CH_W +: CH_W];
      end
    end
  end

  // Pan routing by channel position: ch 0=A, 1=B, 2=C.
  always_comb begin
    to_l = 1'b1;
    to_r = 1'b1;
    case (pan_mode)
      2'd1: begin
        to_l = (ch_idx != 2'd1);
        to_r = (ch_idx != 2'd0);
      end
      2'd2: begin
        to_l = 1'b1;
        to_r = 1'b1;
      end
      default: begin
        to_l = (ch_idx != 2'd2);
        to_r = (ch_idx != 2'd0);
      end
    endcase
  end

  // Clamp to the output range; the accumulator is wide enough never to wrap.
  always_comb begin
    ext_l = SAT_W'(acc_l);
    ext_r = SAT_W'(acc_r);
    sat_l = (ext_l > SAT_MAX) ? {OUT_W{1'b1}} : OUT_W'(acc_l);
    sat_r = (ext_r > SAT_MAX) ? {OUT_W{1'b1}} : OUT_W'(acc_r);
  end

  // Mixer datapath: snapshot, accumulators, published outputs and the
  // sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap         <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      chip_idx     <= 3'd0;
      ch_idx       <= 2'd0;
      audio_left   <= '0;
      audio_right  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= publish;
      if (drop) overrun <= 1'b1;
      if (snap_load) begin
        snap     <= chip_audio;
        acc_l    <= '0;
        acc_r    <= '0;
        chip_idx <= 3'd0;
        ch_idx   <= 2'd0;
      end
      if (acc_step) begin
        acc_l <= acc_l + (to_l ? ACC_W'(chan_val) : ACC_W'(0));
        acc_r <= acc_r + (to_r ? ACC_W'(chan_val) : ACC_W'(0));
        if (ch_idx == 2'd2) begin
          ch_idx   <= 2'd0;
          chip_idx <= chip_idx + 3'd1;
        end else begin
          ch_idx <= ch_idx + 2'd1;
        end
      end
      if (publish) begin
        audio_left  <= sat_l;
        audio_right <= sat_r;
      end
    end
  end

endmodule

// File: tb/tb_turbosound_multi.sv
// Self-checking bench for turbosound_multi with NUM_CHIPS=4. A second
// instance with OUT_W=11 shares all inputs to exercise output saturation.
module tb_turbosound_multi;

  localparam int N   = 4;
  localparam int CHW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              clk35en, clk175en, disable_ay, disable_turboay;
  logic [1:0]        pan_mode;
  logic              bdir, bc1;
  logic [7:0]        din;
  logic [8*N-1:0]    chip_dout;
  logic [N-1:0]      chip_oe_n;
  logic [8*N-1:0]    chip_porta;
  logic [N-1:0]      chip_porta_oe_n;
  logic [3*CHW*N-1:0] chip_audio;

  logic [N-1:0]      chip_ena, chip_a8, chip_ena_s, chip_a8_s;
  logic [11:0]       audio_left, audio_right;
  logic [10:0]       audio_left_s, audio_right_s;
  logic              sample_valid, overrun, sample_valid_s, overrun_s;
`ifdef MIDI_OUT_EN
  logic              midi_out, midi_out_s;
`endif

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;
  int amp [N][3];
  int model_sel;

  turbosound_multi_if bus ();
  turbosound_multi_if bus_s ();

  assign bus.bdir   = bdir;
  assign bus.bc1    = bc1;
  assign bus.din    = din;
  assign bus_s.bdir = bdir;
  assign bus_s.bc1  = bc1;
  assign bus_s.din  = din;

  always #5 clk = ~clk;

  turbosound_multi #(.NUM_CHIPS(N), .CH_W(CHW), .OUT_W(12)) dut (
    .clk(clk), .reset(reset), .clk35en(clk35en), .clk175en(clk175en),
    .disable_ay(disable_ay), .disable_turboay(disable_turboay),
    .pan_mode(pan_mode), .psg(bus.slave),
    .chip_ena(chip_ena), .chip_a8(chip_a8),
    .chip_dout(chip_dout), .chip_oe_n(chip_oe_n),
    .chip_porta(chip_porta), .chip_porta_oe_n(chip_porta_oe_n),
    .chip_audio(chip_audio),
    .audio_left(audio_left), .audio_right(audio_right),
    .sample_valid(sample_valid), .overrun(overrun)
`ifdef MIDI_OUT_EN
    , .midi_out(midi_out)
`endif
  );

  turbosound_multi #(.NUM_CHIPS(N), .CH_W(CHW), .OUT_W(11)) dut_sat (
    .clk(clk), .reset(reset), .clk35en(clk35en), .clk175en(clk175en),
    .disable_ay(disable_ay), .disable_turboay(disable_turboay),
    .pan_mode(pan_mode), .psg(bus_s.slave),
    .chip_ena(chip_ena_s), .chip_a8(chip_a8_s),
    .chip_dout(chip_dout), .chip_oe_n(chip_oe_n),
    .chip_porta(chip_porta), .chip_porta_oe_n(chip_porta_oe_n),
    .chip_audio(chip_audio),
    .audio_left(audio_left_s), .audio_right(audio_right_s),
    .sample_valid(sample_valid_s), .overrun(overrun_s)
`ifdef MIDI_OUT_EN
    , .midi_out(midi_out_s)
`endif
  );

  // Immediate-assertion comparison with pass/fail bookkeeping.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One PSG bus write cycle with bdir=bc1=1.
  task automatic applyStimulus(input logic [7:0] d);
    bdir = 1'b1;
    bc1  = 1'b1;
    din  = d;
    step();
    bdir = 1'b0;
    bc1  = 1'b0;
  endtask

  function automatic bit chipEnabled(input int c);
    return !disable_ay && (c == 0 || !disable_turboay);
  endfunction

  // Expected mix: each channel has a role (left, both, right) from the
  // pan table; sum the enabled channels reaching the requested side and
  // clamp to the output range.
  function automatic int mixModel(input bit want_right, input int out_w);
    int roles [3];
    int sum;
    int limit;
    sum = 0;
    case (pan_mode)
      2'd1:    roles = '{0, 2, 1};
      2'd2:    roles = '{1, 1, 1};
      default: roles = '{0, 1, 2};
    endcase
    for (int c = 0; c < N; c++)
      for (int j = 0; j < 3; j++)
        if (chipEnabled(c) && (want_right ? roles[j] != 0 : roles[j] != 2))
          sum += amp[c][j];
    limit = (1 << out_w) - 1;
    return (sum > limit) ? limit : sum;
  endfunction

  task automatic buildAudio();
    for (int c = 0; c < N; c++)
      for (int j = 0; j < 3; j++)
        chip_audio[(3*c + 2 - j)*CHW +: CHW] = 8'(amp[c][j]);
  endtask

  // Pulse one sample tick, wait (bounded) for sample_valid and compare the
  // published samples of both instances against the model.
  task automatic runSample(input string tag);
    int cyc;
    int el, er, els, ers;
    buildAudio();
    el  = mixModel(1'b0, 12);
    er  = mixModel(1'b1, 12);
    els = mixModel(1'b0, 11);
    ers = mixModel(1'b1, 11);
    clk175en = 1'b1;
    cyc = 0;
    do begin
      step();
      cyc++;
      clk175en = 1'b0;
    end while (!sample_valid && cyc < 60);
    checkOutput({tag, "_latency"}, cyc - 1, 3*N + 2);
    checkOutput({tag, "_left"}, audio_left, el);
    checkOutput({tag, "_right"}, audio_right, er);
    checkOutput({tag, "_left_sat"}, audio_left_s, els);
    checkOutput({tag, "_right_sat"}, audio_right_s, ers);
    step();
    checkOutput({tag, "_valid_pulse"}, sample_valid, 0);
    checkOutput({tag, "_left_hold"}, audio_left, el);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    int idx;
    bit cmd;
    logic [7:0] d;

    reset = 1'b1;
    clk35en = 1'b0; clk175en = 1'b0;
    disable_ay = 1'b0; disable_turboay = 1'b0;
    pan_mode = 2'd0;
    bdir = 1'b0; bc1 = 1'b0; din = 8'h00;
    chip_dout = '0; chip_oe_n = '1;
    chip_porta = '0; chip_porta_oe_n = '1;
    for (int c = 0; c < N; c++) for (int j = 0; j < 3; j++) amp[c][j] = 0;
    buildAudio();
    step(); step();
    $display("[TB] reset state");
    checkOutput("rst_chip_a8", chip_a8, 4'b0001);
    checkOutput("rst_left", audio_left, 0);
    checkOutput("rst_right", audio_right, 0);
    checkOutput("rst_valid", sample_valid, 0);
    checkOutput("rst_overrun", overrun, 0);
    reset = 1'b0;
    step();

    $display("[TB] select and readback");
    chip_dout = 32'($urandom);
    chip_oe_n = 4'b1011;
    applyStimulus(8'hFD);
    checkOutput("sel2_a8", chip_a8, 4'b0100);
    checkOutput("sel2_dout", bus.dout, chip_dout[23:16]);
    checkOutput("sel2_oe_n", bus.oe_n, 0);
    chip_oe_n = 4'b0100;
    chip_dout = 32'($urandom);
    #1;
    checkOutput("sel2_oe_n_track", bus.oe_n, 1);
    checkOutput("sel2_dout_track", bus.dout, chip_dout[23:16]);

    applyStimulus(8'hFB);
    checkOutput("sel_out_of_range", chip_a8, 4'b0100);
    disable_turboay = 1'b1;
    step();
    checkOutput("sel_forced_zero", chip_a8, 4'b0001);
    applyStimulus(8'hFE);
    checkOutput("sel_disabled_target", chip_a8, 4'b0001);
    clk35en = 1'b1; #1;
    checkOutput("ena_turbo_off_hi", chip_ena, 4'b0001);
    clk35en = 1'b0; #1;
    checkOutput("ena_turbo_off_lo", chip_ena, 4'b0000);
    disable_turboay = 1'b0;
    clk35en = 1'b1; #1;
    checkOutput("ena_all_on", chip_ena, 4'b1111);
    disable_ay = 1'b1;
    chip_oe_n = 4'b0000; #1;
    checkOutput("ena_bank_off", chip_ena, 4'b0000);
    checkOutput("oe_n_bank_off", bus.oe_n, 1);
    disable_ay = 1'b0;
    clk35en = 1'b0;
    step();

    $display("[TB] random select sequence");
    model_sel = 0;
    for (int it = 0; it < 24; it++) begin
      disable_ay      = ($urandom_range(0, 7) == 0);
      disable_turboay = ($urandom_range(0, 3) == 0);
      cmd = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 5) == 0) ? 8'($urandom) : (8'hF8 | 8'($urandom_range(0, 7)));
      bdir = cmd; bc1 = cmd; din = d;
      chip_oe_n = 4'($urandom);
      idx = 7 - int'(d[2:0]);
      if (cmd && d[7:3] == 5'b11111 && idx < N && chipEnabled(idx)) model_sel = idx;
      else if (!chipEnabled(model_sel)) model_sel = 0;
      step();
      bdir = 1'b0; bc1 = 1'b0;
      chip_dout = 32'($urandom);
      #1;
      checkOutput("rnd_chip_a8", chip_a8, 32'(1) << model_sel);
      checkOutput("rnd_dout", bus.dout, chip_dout[8*model_sel +: 8]);
      checkOutput("rnd_oe_n", bus.oe_n, chipEnabled(model_sel) ? chip_oe_n[model_sel] : 1'b1);
    end
    disable_ay = 1'b0;
    disable_turboay = 1'b0;
    step();

    $display("[TB] mixer directed");
    pan_mode = 2'd0;
    for (int c = 0; c < N; c++) for (int j = 0; j < 3; j++) amp[c][j] = 0;
    amp[0][0] = 8'h10; amp[0][1] = 8'h20; amp[0][2] = 8'h30;
    runSample("abc");
    checkOutput("abc_left_const", audio_left, 12'h030);
    checkOutput("abc_right_const", audio_right, 12'h050);

    pan_mode = 2'd2;
    for (int c = 0; c < N; c++) for (int j = 0; j < 3; j++) amp[c][j] = 255;
    runSample("mono_full");
    checkOutput("mono_full_const", audio_left, 12'hBF4);
    checkOutput("mono_full_sat_const", audio_right_s, 11'h7FF);

    $display("[TB] mixer random");
    for (int it = 0; it < 8; it++) begin
      pan_mode        = 2'($urandom_range(0, 3));
      disable_turboay = ($urandom_range(0, 2) == 0);
      disable_ay      = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < N; c++)
        for (int j = 0; j < 3; j++)
          amp[c][j] = (it < 4) ? $urandom_range(0, 255) : $urandom_range(160, 255);
      runSample("rnd_mix");
    end
    disable_ay = 1'b0;
    disable_turboay = 1'b0;
    checkOutput("no_overrun_yet", overrun, 0);

    $display("[TB] overrun and reset mid-accumulate");
    pan_mode = 2'd1;
    for (int c = 0; c < N; c++) for (int j = 0; j < 3; j++) amp[c][j] = 16*c + 4*j + 1;
    buildAudio();
    clk175en = 1'b1;
    step();
    clk175en = 1'b0;
    repeat (4) step();
    clk175en = 1'b1;
    step();
    clk175en = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (sample_valid) cnt++;
    end
    checkOutput("overrun_one_sample", cnt, 1);
    checkOutput("overrun_flag", overrun, 1);
    checkOutput("overrun_acb_left", audio_left, mixModel(1'b0, 12));

    clk175en = 1'b1;
    step();
    clk175en = 1'b0;
    repeat (6) step();
    reset = 1'b1;
    #1;
    checkOutput("midacc_rst_left", audio_left, 0);
    checkOutput("midacc_rst_right", audio_right, 0);
    checkOutput("midacc_rst_valid", sample_valid, 0);
    checkOutput("midacc_rst_overrun", overrun, 0);
    step();
    reset = 1'b0;
    step();
    runSample("post_reset");
    checkOutput("post_reset_overrun", overrun, 0);

`ifdef MIDI_OUT_EN
    $display("[TB] midi out");
    applyStimulus(8'hFE);
    chip_porta = '0;
    chip_porta[10] = 1'b1;
    chip_porta_oe_n = 4'b1101;
    #1;
    checkOutput("midi_driven", midi_out, 1);
    chip_porta_oe_n[1] = 1'b1;
    #1;
    checkOutput("midi_not_driven", midi_out, 0);
    chip_porta_oe_n[1] = 1'b0;
    chip_porta[10] = 1'b0;
    #1;
    checkOutput("midi_low", midi_out, 0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
